// File: rtl/video_vga_hsync_gen_if.sv
// video_vga_hsync_gen_if: control inputs and timing outputs of the VGA line generator.
interface video_vga_hsync_gen_if #(parameter int CW = 10);
  logic [1:0]    modes_raster;
  logic          hsync_pol;
  logic          hsync_start;
  logic [CW-1:0] hcount;
  logic          vga_half;
  logic          vga_hsync;
  logic          scanout_start;
  logic          scanout_end;
  logic          scanout_act;
  logic          locked;
  logic          sync_err;
  modport master (
    output modes_raster, hsync_pol, hsync_start,
    input  hcount, vga_half, vga_hsync, scanout_start, scanout_end, scanout_act, locked, sync_err
  );
  modport slave (
    input  modes_raster, hsync_pol, hsync_start,
    output hcount, vga_half, vga_hsync, scanout_start, scanout_end, scanout_act, locked, sync_err
  );
endinterface

// File: rtl/video_vga_hsync_gen.sv
// video_vga_hsync_gen: VGA line counter (two VGA lines per TV line) with hsync, scanout window and lock tracking.
module video_vga_hsync_gen #(
  parameter int CW          = 10,
  parameter int PERIOD0     = 896,
  parameter int PERIOD1     = 896,
  parameter int PERIOD2     = 896,
  parameter int PERIOD3     = 912,
  parameter int HSYNC_END   = 106,
  parameter int SCANOUT_BEG = 156,
  parameter int SCANOUT_END = 876,
  parameter int RESYNC_LOAD = 2,
  parameter int LOCK_CNT    = 4
) (
  input logic clk,
  input logic rst,
  video_vga_hsync_gen_if.slave bus
);
  localparam int LW = $clog2(LOCK_CNT + 1);
  typedef enum logic [1:0] {UNLOCK, LOCKING, LOCKED} state_t;
  logic [CW-1:0] hcount, period_m1;
  logic          half, s, s_next, hsync_q, ss_q, se_q, sa_q;
  logic          wrap, pre_load, on_time, missed, bad;
  logic          locked_q, err_q, locked_next, err_next;
  state_t        state, state_next;
  logic [LW-1:0] lc, lc_next;
  always_comb begin
    period_m1 = bus.modes_raster == 2'd0 ? CW'(PERIOD0 - 1) :
                bus.modes_raster == 2'd1 ? CW'(PERIOD1 - 1) :
                bus.modes_raster == 2'd2 ? CW'(PERIOD2 - 1) : CW'(PERIOD3 - 1);
    wrap      = hcount >= period_m1;
    pre_load  = hcount == CW'(RESYNC_LOAD - 1) && !half;
    on_time   = bus.hsync_start && pre_load;
    // a line start that should have arrived: the counter is about to step onto the load value itself
    missed    = !bus.hsync_start && !wrap && pre_load;
    bad       = (bus.hsync_start && !on_time) || missed;
    s_next    = hcount == '0 ? 1'b1 : hcount == CW'(HSYNC_END) ? 1'b0 : s;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      half   <= 1'b0;
    end else if (bus.hsync_start) begin
      hcount <= CW'(RESYNC_LOAD);
      half   <= 1'b0;
    end else if (wrap) begin
      hcount <= '0;
      half   <= ~half;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s       <= 1'b0;
      hsync_q <= bus.hsync_pol;
      ss_q    <= 1'b0;
      se_q    <= 1'b0;
      sa_q    <= 1'b0;
    end else begin
      s       <= s_next;
      hsync_q <= s_next ^ bus.hsync_pol;
      ss_q    <= hcount == CW'(SCANOUT_BEG);
      se_q    <= hcount == CW'(SCANOUT_END);
      sa_q    <= hcount == CW'(SCANOUT_BEG) ? 1'b1 : hcount == CW'(SCANOUT_END) ? 1'b0 : sa_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNLOCK;
      lc       <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      lc       <= lc_next;
      locked_q <= locked_next;
      err_q    <= err_next;
    end
  end
  always_comb begin
    state_next = state;
    lc_next    = lc;
    if (on_time) begin
      lc_next    = state == LOCKED ? lc : lc + 1'b1;
      state_next = (state == LOCKED || lc + 1'b1 == LW'(LOCK_CNT)) ? LOCKED : LOCKING;
    end else if (bad) begin
      state_next = UNLOCK;
      lc_next    = '0;
    end
  end
  always_comb begin
    locked_next = state_next == LOCKED;
    err_next    = bad && state != UNLOCK;
  end
  assign bus.hcount        = hcount;
  assign bus.vga_half      = half;
  assign bus.vga_hsync     = hsync_q;
  assign bus.scanout_start = ss_q;
  assign bus.scanout_end   = se_q;
  assign bus.scanout_act   = sa_q;
  assign bus.locked        = locked_q;
  assign bus.sync_err      = err_q;
endmodule
